// File: rtl/retire_trace_fifo.sv
// Retirement trace transmitter: captures per-cycle retire events into a small
// FIFO, drains them over valid/ready, and keeps instruction/cache statistics.
module retire_trace_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             evt_regwrite,
  input  logic [2:0]       evt_writereg,
  input  logic [15:0]      evt_writedata,
  input  logic             evt_memread,
  input  logic             evt_memwrite,
  input  logic [15:0]      evt_memaddr,
  input  logic [15:0]      evt_memdatain,
  input  logic [15:0]      evt_memdataout,
  input  logic             evt_halt,
  input  logic             icache_req,
  input  logic             icache_hit,
  input  logic             dcache_req,
  input  logic             dcache_hit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_flags,
  output logic [2:0]       out_reg,
  output logic [15:0]      out_addr,
  output logic [15:0]      out_data,
  output logic [15:0]      out_mdata,
  output logic             fifo_full,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_count,
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] icache_req_count,
  output logic [CNT_W-1:0] icache_hit_count,
  output logic [CNT_W-1:0] dcache_req_count,
  output logic [CNT_W-1:0] dcache_hit_count,
  output logic             done
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW = AW + 1;

  // One trace record; flags are {halt, memwrite, memread, regwrite}
  typedef struct packed {
    logic [3:0]  flags;
    logic [2:0]  wreg;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] mdata;
  } traceRec_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t    state;
  traceRec_t mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [OW-1:0] occ;

  traceRec_t newRec;
  traceRec_t headRec;
  logic      evtPresent;
  logic      isFull;
  logic      isRun;
  logic      popFire;
  logic      pushFire;
  logic      dropFire;
  logic      instEvt;
  logic      notDone;

  // Event decode and handshake qualification
  always_comb begin
    evtPresent   = evt_regwrite | evt_memread | evt_memwrite | evt_halt;
    isFull       = (occ == OW'(DEPTH));
    isRun        = (state == RUN);
    notDone      = (state != DONE);
    headRec      = mem[rdPtr];
    popFire      = (occ != OW'(0)) & notDone & out_ready;
    pushFire     = evtPresent & isRun & (~isFull | popFire);
    dropFire     = evtPresent & isRun & isFull & ~popFire;
    instEvt      = evt_halt | evt_regwrite | evt_memwrite;
    newRec.flags = {evt_halt, evt_memwrite, evt_memread, evt_regwrite};
    newRec.wreg  = evt_writereg;
    newRec.addr  = evt_memaddr;
    newRec.wdata = evt_writedata;
    newRec.mdata = evt_memread ? evt_memdataout : evt_memdatain;
  end

  // Output view of the FIFO head; fields read as zero when nothing is offered
  always_comb begin
    out_valid = (occ != OW'(0)) & notDone;
    out_flags = out_valid ? headRec.flags : 4'h0;
    out_reg   = out_valid ? headRec.wreg  : 3'h0;
    out_addr  = out_valid ? headRec.addr  : 16'h0;
    out_data  = out_valid ? headRec.wdata : 16'h0;
    out_mdata = out_valid ? headRec.mdata : 16'h0;
    fifo_full = isFull;
    done      = (state == DONE);
  end

  // Storage array; contents need no reset since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (pushFire) begin
      mem[wrPtr] <= newRec;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at a power-of-two depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      occ   <= '0;
    end else begin
      if (pushFire) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (popFire) begin
        rdPtr <= rdPtr + AW'(1);
      end
      if (pushFire && !popFire) begin
        occ <= occ + OW'(1);
      end else if (popFire && !pushFire) begin
        occ <= occ - OW'(1);
      end
    end
  end

  // Trace state: halt record closes the stream, its pop completes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      case (state)
        RUN: begin
          if (pushFire && evt_halt) begin
            state <= HALTED;
          end
        end
        HALTED: begin
          if (popFire && headRec.flags[3]) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  // Drop tracking for events lost to a full FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (dropFire) begin
      overflow   <= 1'b1;
      drop_count <= drop_count + CNT_W'(1);
    end
  end

  // Retired-instruction counter covers both accepted and dropped events
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_count <= '0;
    end else if ((pushFire || dropFire) && instEvt) begin
      inst_count <= inst_count + CNT_W'(1);
    end
  end

  // Cache activity counters, frozen once the trace is done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      icache_req_count <= '0;
      icache_hit_count <= '0;
      dcache_req_count <= '0;
      dcache_hit_count <= '0;
    end else if (notDone) begin
      if (icache_req) icache_req_count <= icache_req_count + CNT_W'(1);
      if (icache_hit) icache_hit_count <= icache_hit_count + CNT_W'(1);
      if (dcache_req) dcache_req_count <= dcache_req_count + CNT_W'(1);
      if (dcache_hit) dcache_hit_count <= dcache_hit_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_retire_trace_fifo.sv
// Self-checking bench for retire_trace_fifo: directed scenarios plus random
// traffic compared every cycle against a queue-based reference model.
module tb_retire_trace_fifo;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        evt_regwrite;
  logic [2:0]  evt_writereg;
  logic [15:0] evt_writedata;
  logic        evt_memread;
  logic        evt_memwrite;
  logic [15:0] evt_memaddr;
  logic [15:0] evt_memdatain;
  logic [15:0] evt_memdataout;
  logic        evt_halt;
  logic        icache_req, icache_hit, dcache_req, dcache_hit;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_flags;
  logic [2:0]  out_reg;
  logic [15:0] out_addr, out_data, out_mdata;
  logic        fifo_full, overflow, done;
  logic [31:0] drop_count, inst_count;
  logic [31:0] icache_req_count, icache_hit_count, dcache_req_count, dcache_hit_count;

  retire_trace_fifo #(.DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .evt_regwrite(evt_regwrite), .evt_writereg(evt_writereg), .evt_writedata(evt_writedata),
    .evt_memread(evt_memread), .evt_memwrite(evt_memwrite), .evt_memaddr(evt_memaddr),
    .evt_memdatain(evt_memdatain), .evt_memdataout(evt_memdataout), .evt_halt(evt_halt),
    .icache_req(icache_req), .icache_hit(icache_hit), .dcache_req(dcache_req), .dcache_hit(dcache_hit),
    .out_valid(out_valid), .out_ready(out_ready), .out_flags(out_flags), .out_reg(out_reg),
    .out_addr(out_addr), .out_data(out_data), .out_mdata(out_mdata),
    .fifo_full(fifo_full), .overflow(overflow), .drop_count(drop_count),
    .inst_count(inst_count), .icache_req_count(icache_req_count), .icache_hit_count(icache_hit_count),
    .dcache_req_count(dcache_req_count), .dcache_hit_count(dcache_hit_count), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of records plus counters and a run/halted/done phase
  typedef struct {
    logic [3:0]  f;
    logic [2:0]  r;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] m;
  } rec_t;

  rec_t        q[$];
  int          mPhase;      // 0 running, 1 halt captured, 2 finished
  logic        mOvf;
  logic [31:0] mDrop, mInst, mIcR, mIcH, mDcR, mDcH;

  int checks = 0;
  int errors = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    q.delete();
    mPhase = 0;
    mOvf = 1'b0;
    mDrop = 0; mInst = 0; mIcR = 0; mIcH = 0; mDcR = 0; mDcH = 0;
  endtask

  // Apply one clock of the model using the inputs currently driven
  task automatic modelStep();
    bit   evt, pop, popHalt, acc;
    rec_t nr;
    int   ph;
    ph      = mPhase;
    evt     = evt_regwrite | evt_memread | evt_memwrite | evt_halt;
    pop     = (q.size() > 0) && out_ready && (ph != 2);
    popHalt = pop && q[0].f[3];
    acc     = 1'b0;
    if (ph == 0 && evt) begin
      if (q.size() < DEPTH || pop) begin
        acc  = 1'b1;
        nr.f = {evt_halt, evt_memwrite, evt_memread, evt_regwrite};
        nr.r = evt_writereg;
        nr.a = evt_memaddr;
        nr.d = evt_writedata;
        nr.m = evt_memread ? evt_memdataout : evt_memdatain;
        if (evt_halt) mPhase = 1;
      end else begin
        mOvf = 1'b1;
        mDrop++;
      end
      if (evt_halt | evt_regwrite | evt_memwrite) mInst++;
    end
    if (ph != 2) begin
      if (icache_req) mIcR++;
      if (icache_hit) mIcH++;
      if (dcache_req) mDcR++;
      if (dcache_hit) mDcH++;
    end
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(nr);
    if (popHalt) mPhase = 2;
  endtask

  task automatic checkAll();
    bit   v;
    rec_t h;
    v = (q.size() > 0);
    h = v ? q[0] : '{4'h0, 3'h0, 16'h0, 16'h0, 16'h0};
    checkVal("out_valid", out_valid, v);
    checkVal("out_flags", out_flags, h.f);
    checkVal("out_reg", out_reg, h.r);
    checkVal("out_addr", out_addr, h.a);
    checkVal("out_data", out_data, h.d);
    checkVal("out_mdata", out_mdata, h.m);
    checkVal("fifo_full", fifo_full, (q.size() == DEPTH));
    checkVal("overflow", overflow, mOvf);
    checkVal("drop_count", drop_count, mDrop);
    checkVal("inst_count", inst_count, mInst);
    checkVal("icache_req_count", icache_req_count, mIcR);
    checkVal("icache_hit_count", icache_hit_count, mIcH);
    checkVal("dcache_req_count", dcache_req_count, mDcR);
    checkVal("dcache_hit_count", dcache_hit_count, mDcH);
    checkVal("done", done, (mPhase == 2));
  endtask

  task automatic clearInputs();
    evt_regwrite = 0; evt_writereg = 0; evt_writedata = 0;
    evt_memread = 0; evt_memwrite = 0; evt_memaddr = 0;
    evt_memdatain = 0; evt_memdataout = 0; evt_halt = 0;
    icache_req = 0; icache_hit = 0; dcache_req = 0; dcache_hit = 0;
  endtask

  // Advance one clock and compare every output against the model
  task automatic step();
    modelStep();
    @(posedge clk);
    #1;
    checkAll();
  endtask

  // Asynchronous reset asserted between edges, checked before any edge
  task automatic doReset();
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checkAll();
    clearInputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [31:0] savedInst, savedIc;

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    clearInputs();
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkAll();

    // Three queued records, then reset mid-cycle
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      clearInputs();
      evt_regwrite = 1; evt_writereg = 3'(i); evt_writedata = 16'(i + 7);
      icache_req = 1;
      step();
    end
    clearInputs();
    doReset();
    checkVal("rst_valid", out_valid, 1'b0);
    checkVal("rst_inst", inst_count, 32'd0);
    checkVal("rst_icache", icache_req_count, 32'd0);

    // Single register write
    out_ready = 1'b1;
    evt_regwrite = 1; evt_writereg = 3'd5; evt_writedata = 16'h1234;
    step();
    checkVal("rw_valid", out_valid, 1'b1);
    checkVal("rw_flags", out_flags, 4'b0001);
    checkVal("rw_reg", out_reg, 3'd5);
    checkVal("rw_data", out_data, 16'h1234);
    clearInputs();
    step();
    checkVal("rw_inst", inst_count, 32'd1);
    checkVal("rw_popped", out_valid, 1'b0);

    // Load with writeback
    evt_memread = 1; evt_regwrite = 1; evt_memaddr = 16'h0040;
    evt_memdataout = 16'hBEEF; evt_memdatain = 16'h5555; evt_writereg = 3'd2;
    step();
    checkVal("ld_flags", out_flags, 4'b0011);
    checkVal("ld_addr", out_addr, 16'h0040);
    checkVal("ld_mdata", out_mdata, 16'hBEEF);
    clearInputs();
    step();
    checkVal("ld_inst", inst_count, 32'd2);

    // Ten stores into a stalled consumer
    savedInst = inst_count;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      clearInputs();
      evt_memwrite = 1; evt_memaddr = 16'(16'h0100 + i); evt_memdatain = 16'(16'hA000 + i);
      step();
    end
    clearInputs();
    checkVal("st_full", fifo_full, 1'b1);
    checkVal("st_ovf", overflow, 1'b1);
    checkVal("st_drop", drop_count, 32'd2);
    checkVal("st_inst", inst_count - savedInst, 32'd10);
    checkVal("st_head_addr", out_addr, 16'h0100);

    // Push and pop together while full
    out_ready = 1'b1;
    evt_memwrite = 1; evt_memaddr = 16'h0200; evt_memdatain = 16'hC0DE;
    step();
    checkVal("fp_full", fifo_full, 1'b1);
    checkVal("fp_drop", drop_count, 32'd2);
    checkVal("fp_head_addr", out_addr, 16'h0101);
    clearInputs();
    for (int i = 0; i < 9; i++) step();
    checkVal("drain_empty", out_valid, 1'b0);

    // Halt followed by two register writes
    evt_halt = 1; icache_req = 1;
    step();
    checkVal("halt_flags", out_flags, 4'b1000);
    clearInputs();
    evt_regwrite = 1; evt_writereg = 3'd1; evt_writedata = 16'h1111; icache_req = 1;
    step();
    checkVal("halt_done", done, 1'b1);
    evt_writereg = 3'd3; evt_writedata = 16'h3333;
    step();
    savedIc = icache_req_count;
    clearInputs();
    icache_req = 1; icache_hit = 1; dcache_req = 1; dcache_hit = 1;
    for (int i = 0; i < 3; i++) step();
    checkVal("frozen_icache", icache_req_count, savedIc);
    checkVal("frozen_valid", out_valid, 1'b0);
    clearInputs();
    doReset();

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      clearInputs();
      if ($urandom_range(0, 99) < 55) begin
        evt_regwrite   = 1'($urandom_range(0, 1));
        evt_memread    = 1'($urandom_range(0, 1));
        evt_halt       = ($urandom_range(0, 39) == 0);
        evt_memwrite   = evt_halt ? 1'b0 : 1'($urandom_range(0, 1));
      end
      evt_writereg   = 3'($urandom);
      evt_writedata  = 16'($urandom);
      evt_memaddr    = 16'($urandom);
      evt_memdatain  = 16'($urandom);
      evt_memdataout = 16'($urandom);
      icache_req = 1'($urandom_range(0, 1));
      icache_hit = 1'($urandom_range(0, 1));
      dcache_req = 1'($urandom_range(0, 1));
      dcache_hit = 1'($urandom_range(0, 1));
      out_ready  = ($urandom_range(0, 99) < 45);
      step();
      if (mPhase == 2 && $urandom_range(0, 3) == 0) begin
        clearInputs();
        doReset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/retire_trace_fifo.md
Name: retire_trace_fifo

Overview:
Synthesizable transmitter for the per-cycle retirement trace that the simulation monitor consumes today by hierarchical probing. It sits next to the processor's memory/writeback stages and captures each retirement event: register write, load, store and halt. Events are buffered in a small FIFO and drained to a consumer (logger, debug port) over a valid/ready handshake. It also keeps the instruction and cache request/hit counters in hardware.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2.
CNT_W, 32, width of every statistics counter.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
evt_regwrite  input  1  register file written this cycle
evt_writereg  input  3  destination register
evt_writedata  input  16  register write data
evt_memread  input  1  load this cycle
evt_memwrite  input  1  store this cycle (already excludes halt)
evt_memaddr  input  16  memory address
evt_memdatain  input  16  store data
evt_memdataout  input  16  load data
evt_halt  input  1  halt in memory stage
icache_req, icache_hit, dcache_req, dcache_hit  input  1 each  cache activity strobes
out_valid  output  1  record available
out_ready  input  1  consumer accepts record
out_flags  output  4  {halt, memwrite, memread, regwrite}
out_reg  output  3  record register
out_addr  output  16  record address
out_data  output  16  regwrite data
out_mdata  output  16  load data if memread, else store data
fifo_full  output  1  FIFO full (pipeline may stall on this)
overflow  output  1  sticky: at least one event dropped
drop_count  output  CNT_W  events dropped
inst_count, icache_req_count, icache_hit_count, dcache_req_count, dcache_hit_count  output  CNT_W each  statistics
done  output  1  halt record consumed and FIFO empty

Behaviour:
- Reset: asynchronous and active-high. All outputs are 0, FIFO is empty, and state is RUN. rst asserted mid-drain discards the FIFO contents immediately.
- Event present = regwrite | memread | memwrite | halt. One record is formed per event cycle. Combined flags are allowed; for example, a load with writeback sets memread and regwrite in the same record.
- Record fields: out_mdata = memread ? evt_memdataout : evt_memdatain. Fields not selected by the flags are captured as presented, with no zeroing.
- Push is accepted when an event is present, state is RUN, and either the FIFO is not full or a pop occurs in the same cycle. Full plus simultaneous pop: push is accepted and occupancy is unchanged.
- Empty plus simultaneous push: there is no bypass. out_valid rises on the next cycle, so push-to-output latency is 1 cycle.
- Pop occurs when out_valid and out_ready are both high. Output fields are stable while out_valid is high and out_ready is low.
- Read and write pointers wrap modulo DEPTH. A separate occupancy count (log2(DEPTH)+1 bits) distinguishes full from empty.
- Push rejected while in RUN (FIFO full, no pop): the event is dropped, overflow sets sticky until rst, and drop_count increments.
- inst_count increments on each accepted or dropped event with halt | regwrite | memwrite.
- Each cache counter increments on its strobe while state is not DONE.
- All counters wrap modulo 2^CNT_W.
- State machine:
  - RUN -> HALTED when a record with halt is pushed. Events arriving after that cycle are ignored: not pushed and not counted as drops.
  - HALTED -> DONE when the halt record is popped. The halt record is always the last entry in the FIFO.
  - DONE is terminal until rst. done = 1, out_valid = 0, all counters frozen.
  - A halt event rejected because the FIFO is full is dropped like any other event, and state stays RUN.
- fifo_full is combinational from occupancy == DEPTH.

Test Plan:
1. rst pulse mid-cycle with 3 entries queued -> out_valid = 0, all counters 0, and overflow 0 immediately, with no clock edge needed.
2. Single regwrite (reg 5, data 0x1234) with out_ready = 1 -> next cycle out_valid = 1, flags 0001, reg 5, data 0x1234; popped; inst_count = 1.
3. Load (memread + regwrite, addr 0x0040, dataout 0xBEEF) -> flags 0011, addr 0x0040, mdata 0xBEEF; inst_count unchanged by memread alone.
4. out_ready = 0 and 10 consecutive stores with DEPTH = 8 -> fifo_full after 8, overflow = 1, drop_count = 2, inst_count = 10; the 8 records then drain in order.
5. Full FIFO, push and pop in the same cycle -> push accepted, occupancy stays 8, no drop.
6. Halt followed by 2 more regwrites, with out_ready = 1 -> halt record is last (flags 1000), the trailing events are ignored, done = 1 the cycle after the halt pop, and cache counters then freeze.
